// File: rtl/mips_core_pkg.sv
// Shared core types: address width, branch outcome, and the BTB entry layout.
package mips_core_pkg;

    localparam int ADDR_WIDTH     = 32;
    localparam int BTB_INDEX_BITS = 6;
    // Tag field is sized for the smallest legal index so any INDEX_BITS fits.
    localparam int BTB_TAG_W      = ADDR_WIDTH - 2;

    typedef enum logic {
        NOT_TAKEN = 1'b0,
        TAKEN     = 1'b1
    } BranchOutcome;

    localparam logic [1:0] CTR_STRONG_NT = 2'b00;
    localparam logic [1:0] CTR_WEAK_NT   = 2'b01;
    localparam logic [1:0] CTR_WEAK_T    = 2'b10;
    localparam logic [1:0] CTR_STRONG_T  = 2'b11;

    typedef struct packed {
        logic                  valid;
        logic [BTB_TAG_W-1:0]  tag;
        logic [ADDR_WIDTH-1:0] target;
        logic [1:0]            ctr;
    } btb_entry_t;

endpackage

// File: rtl/branch_target_buffer_if.sv
// Fetch lookup and EX training signals of the branch target buffer.
interface branch_target_buffer_if
    import mips_core_pkg::*;
();
    logic                  i_flush;
    logic [ADDR_WIDTH-1:0] i_lookup_pc;
    logic                  o_hit;
    logic                  o_pred_taken;
    logic [ADDR_WIDTH-1:0] o_pred_target;
    logic                  i_upd_valid;
    logic [ADDR_WIDTH-1:0] i_upd_pc;
    logic [ADDR_WIDTH-1:0] i_upd_target;
    BranchOutcome          i_upd_outcome;
    logic                  i_upd_is_jump;

    modport master (
        output i_flush, i_lookup_pc, i_upd_valid, i_upd_pc, i_upd_target,
               i_upd_outcome, i_upd_is_jump,
        input  o_hit, o_pred_taken, o_pred_target
    );

    modport slave (
        input  i_flush, i_lookup_pc, i_upd_valid, i_upd_pc, i_upd_target,
               i_upd_outcome, i_upd_is_jump,
        output o_hit, o_pred_taken, o_pred_target
    );
endinterface

// File: rtl/btb_sat_counter.sv
// Next-state logic for a 2-bit saturating direction counter.
module btb_sat_counter
    import mips_core_pkg::*;
(
    input  logic [1:0]   ctr,
    input  BranchOutcome outcome,
    input  logic         is_jump,
    input  logic         alloc,
    output logic [1:0]   ctr_next
);
    always_comb begin
        ctr_next = ctr;
        if (is_jump) begin
            ctr_next = CTR_STRONG_T;
        end else if (alloc) begin
            ctr_next = CTR_WEAK_T;
        end else if (outcome == TAKEN) begin
            if (ctr != CTR_STRONG_T) ctr_next = ctr + 2'd1;
        end else begin
            if (ctr != CTR_STRONG_NT) ctr_next = ctr - 2'd1;
        end
    end
endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer: zero-latency lookup, trained from EX.
module branch_target_buffer
    import mips_core_pkg::*;
#(
    parameter int INDEX_BITS = BTB_INDEX_BITS
) (
    input logic                    clk,
    input logic                    rst_n,
    branch_target_buffer_if.slave  bus
);
    localparam int          TAG_BITS = ADDR_WIDTH - INDEX_BITS - 2;
    localparam int unsigned ENTRIES  = 1 << INDEX_BITS;

    btb_entry_t table_q [ENTRIES];

    logic [INDEX_BITS-1:0] lk_idx;
    logic [BTB_TAG_W-1:0]  lk_tag;
    btb_entry_t            lk_entry;
    logic                  lk_hit;

    logic [INDEX_BITS-1:0] up_idx;
    logic [BTB_TAG_W-1:0]  up_tag;
    btb_entry_t            up_entry;
    logic                  up_hit;
    logic                  up_writes_target;
    logic [1:0]            ctr_next;

    logic unused_pc_bits;
    assign unused_pc_bits = ^{bus.i_lookup_pc[1:0], bus.i_upd_pc[1:0]};

    // Tags are zero-extended into the fixed-width struct field.
    assign lk_idx   = bus.i_lookup_pc[INDEX_BITS+1:2];
    assign lk_tag   = BTB_TAG_W'(bus.i_lookup_pc[ADDR_WIDTH-1:INDEX_BITS+2]);
    assign lk_entry = table_q[lk_idx];

    always_comb begin
        lk_hit            = lk_entry.valid && (lk_entry.tag == lk_tag);
        bus.o_hit         = lk_hit;
        bus.o_pred_taken  = lk_hit && lk_entry.ctr[1];
        bus.o_pred_target = lk_hit ? lk_entry.target : '0;
    end

    assign up_idx           = bus.i_upd_pc[INDEX_BITS+1:2];
    assign up_tag           = BTB_TAG_W'(bus.i_upd_pc[ADDR_WIDTH-1:INDEX_BITS+2]);
    assign up_entry         = table_q[up_idx];
    assign up_hit           = up_entry.valid && (up_entry.tag == up_tag);
    assign up_writes_target = (bus.i_upd_outcome == TAKEN) || bus.i_upd_is_jump;

    btb_sat_counter u_ctr (
        .ctr      (up_entry.ctr),
        .outcome  (bus.i_upd_outcome),
        .is_jump  (bus.i_upd_is_jump),
        .alloc    (!up_hit),
        .ctr_next (ctr_next)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                table_q[i].valid <= 1'b0;
                table_q[i].ctr   <= CTR_WEAK_NT;
            end
        end else if (bus.i_flush) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                table_q[i].valid <= 1'b0;
            end
        end else if (bus.i_upd_valid) begin
            if (up_hit) begin
                table_q[up_idx].ctr <= ctr_next;
                if (up_writes_target) table_q[up_idx].target <= bus.i_upd_target;
            end else if (up_writes_target) begin
                table_q[up_idx] <= '{valid:  1'b1,
                                     tag:    up_tag,
                                     target: bus.i_upd_target,
                                     ctr:    ctr_next};
            end
        end
    end

    if (TAG_BITS < 1) begin : g_bad_index
        $error("INDEX_BITS leaves no tag bits");
    end
endmodule

// File: tb/tb_branch_target_buffer.sv
// Scoreboard bench for branch_target_buffer against a table-of-records model.
module tb_branch_target_buffer;
    import mips_core_pkg::*;

    typedef struct packed {
        logic        hit;
        logic        taken;
        logic [31:0] target;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    branch_target_buffer_if bus ();

    branch_target_buffer #(.INDEX_BITS(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Reference model: one record per index, counter kept as an integer 0..3.
    bit          m_valid [64];
    int unsigned m_tag   [64];
    logic [31:0] m_tgt   [64];
    int          m_ctr   [64];

    exp_t  exp_q  [$];
    string name_q [$];
    int vectors     = 0;
    int miscompares = 0;

    function automatic exp_t model_lookup(input logic [31:0] pc);
        int unsigned idx = (pc >> 2) % 64;
        int unsigned tag = pc >> 8;
        exp_t e;
        e = '0;
        if (m_valid[idx] && m_tag[idx] == tag) begin
            e.hit    = 1'b1;
            e.taken  = (m_ctr[idx] >= 2);
            e.target = m_tgt[idx];
        end
        return e;
    endfunction

    task automatic model_update(input bit rst, input bit flush, input bit uv,
                                input logic [31:0] pc, input logic [31:0] tgt,
                                input bit taken, input bit jump);
        int unsigned idx = (pc >> 2) % 64;
        int unsigned tag = pc >> 8;
        if (rst) begin
            for (int i = 0; i < 64; i++) begin
                m_valid[i] = 0;
                m_ctr[i]   = 1;
            end
        end else if (flush) begin
            for (int i = 0; i < 64; i++) m_valid[i] = 0;
        end else if (uv) begin
            if (m_valid[idx] && m_tag[idx] == tag) begin
                if (jump) begin
                    m_ctr[idx] = 3;
                    m_tgt[idx] = tgt;
                end else if (taken) begin
                    m_ctr[idx] = (m_ctr[idx] < 3) ? m_ctr[idx] + 1 : 3;
                    m_tgt[idx] = tgt;
                end else begin
                    m_ctr[idx] = (m_ctr[idx] > 0) ? m_ctr[idx] - 1 : 0;
                end
            end else if (taken || jump) begin
                m_valid[idx] = 1;
                m_tag[idx]   = tag;
                m_tgt[idx]   = tgt;
                m_ctr[idx]   = jump ? 3 : 2;
            end
        end
    endtask

    // One cycle: drive, record the pre-edge expected lookup, advance the model.
    task automatic step(input string name, input logic [31:0] lpc,
                        input bit rst = 0, input bit flush = 0, input bit uv = 0,
                        input logic [31:0] upc = '0, input logic [31:0] utgt = '0,
                        input bit taken = 0, input bit jump = 0);
        @(posedge clk);
        #1;
        rst_n             = !rst;
        bus.i_flush       = flush;
        bus.i_lookup_pc   = lpc;
        bus.i_upd_valid   = uv;
        bus.i_upd_pc      = upc;
        bus.i_upd_target  = utgt;
        bus.i_upd_outcome = taken ? TAKEN : NOT_TAKEN;
        bus.i_upd_is_jump = jump;
        exp_q.push_back(model_lookup(lpc));
        name_q.push_back(name);
        model_update(rst, flush, uv, upc, utgt, taken, jump);
    endtask

    task automatic check_field(input string name, input string field,
                               input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s.%s: got 0x%08h, expected 0x%08h", name, field, act, req);
        end
    endtask

    initial begin : monitor
        exp_t  e;
        string n;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                check_field(n, "hit",    32'(bus.o_hit),        32'(e.hit));
                check_field(n, "taken",  32'(bus.o_pred_taken), 32'(e.taken));
                check_field(n, "target", bus.o_pred_target,     e.target);
            end
        end
    end

    function automatic logic [31:0] rand_pc();
        return 32'h0040_0000 + ($urandom_range(0, 3) << 8)
             + ($urandom_range(0, 7) << 2) + $urandom_range(0, 3);
    endfunction

    initial begin : driver
        rst_n             = 1'b0;
        bus.i_flush       = 1'b0;
        bus.i_lookup_pc   = '0;
        bus.i_upd_valid   = 1'b0;
        bus.i_upd_pc      = '0;
        bus.i_upd_target  = '0;
        bus.i_upd_outcome = NOT_TAKEN;
        bus.i_upd_is_jump = 1'b0;
        model_update(1, 0, 0, '0, '0, 0, 0);
        repeat (2) @(posedge clk);

        step("reset_lookup", 32'h0040_0010);
        step("same_cycle",   32'h0040_0010, 0, 0, 1, 32'h0040_0010, 32'h0040_0100, 1, 0);
        step("alloc_hit",    32'h0040_0010);
        step("nt1",          32'h0040_0010, 0, 0, 1, 32'h0040_0010, 32'h0, 0, 0);
        step("nt2",          32'h0040_0010, 0, 0, 1, 32'h0040_0010, 32'h0, 0, 0);
        step("nt3_sat",      32'h0040_0010, 0, 0, 1, 32'h0040_0010, 32'h0, 0, 0);
        step("t1",           32'h0040_0010, 0, 0, 1, 32'h0040_0010, 32'h0040_0100, 1, 0);
        step("t2",           32'h0040_0010, 0, 0, 1, 32'h0040_0010, 32'h0040_0100, 1, 0);
        step("weak_taken",   32'h0040_0010, 0, 0, 1, 32'h0040_0020, 32'h0040_0999, 0, 0);
        step("nt_no_alloc",  32'h0040_0020, 0, 0, 1, 32'h0040_0020, 32'h0040_0400, 0, 1);
        step("jump_hit",     32'h0040_0020, 0, 0, 1, 32'h0040_0020, 32'h0, 0, 0);
        step("jump_strong",  32'h0040_0020, 0, 0, 1, 32'h0040_0110, 32'h0040_0500, 1, 0);
        step("alias_evict",  32'h0040_0010);
        step("alias_new",    32'h0040_0110, 0, 1, 1, 32'h0040_0030, 32'h0040_0600, 1, 0);
        step("flush_30",     32'h0040_0030);
        step("flush_110",    32'h0040_0110, 0, 0, 1, 32'h0040_0110, 32'h0040_0700, 1, 0);
        step("pre_reset",    32'h0040_0110, 1, 0, 1, 32'h0040_0110, 32'h0040_0800, 1, 0);
        step("post_reset",   32'h0040_0110);

        for (int i = 0; i < 3000; i++) begin
            step("random", rand_pc(), ($urandom_range(0, 499) == 0),
                 ($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
                 rand_pc(), $urandom, ($urandom_range(0, 1) == 1),
                 ($urandom_range(0, 7) == 0));
        end

        repeat (3) @(posedge clk);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d pending, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
